// File: rtl/peak_tracker.sv
// peak_tracker
//   Tracks the best (highest) match score over one frame of template-match
//   results and reports its coordinate, clamped so the template window stays
//   inside the frame.
//
//   state  | meaning
//   IDLE   | waiting for frame_start with tracking_mode high
//   SCAN   | accumulating the best score/coordinate of the current frame
//   REPORT | one-cycle state in which max_ready or lost is visible
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   tracking_mode       enables the search; low forces IDLE
//   frame_start/end     one-cycle pulses bracketing the scores of a frame
//   score_valid         qualifies score, x, y
//   x, y, score         current template-centre coordinate and match score
//   max_x, max_y        registered (clamped) peak coordinate
//   max_score           registered peak score
//   max_ready           pulse: max_* updated this cycle
//   lost                pulse: frame ended with no score above THRESH

`ifndef TEMPLATE_WIDTH
`define TEMPLATE_WIDTH 32
`endif
`ifndef VGA_WIDTH
`define VGA_WIDTH 640
`endif
`ifndef VGA_HEIGHT
`define VGA_HEIGHT 480
`endif

module peak_tracker #(
  parameter int SCORE_W = 16,
  parameter int THRESH  = 0,
  parameter int HALF    = `TEMPLATE_WIDTH / 2,
  parameter int XMAX    = `VGA_WIDTH,
  parameter int YMAX    = `VGA_HEIGHT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tracking_mode,
  input  logic               frame_start,
  input  logic               frame_end,
  input  logic               score_valid,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic [SCORE_W-1:0] score,
  output logic [9:0]         max_x,
  output logic [9:0]         max_y,
  output logic [SCORE_W-1:0] max_score,
  output logic               max_ready,
  output logic               lost
);

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  localparam logic [9:0]         X_LO     = 10'(HALF);
  localparam logic [9:0]         X_HI     = 10'(XMAX - 1 - HALF);
  localparam logic [9:0]         Y_LO     = 10'(HALF);
  localparam logic [9:0]         Y_HI     = 10'(YMAX - 1 - HALF);
  localparam logic [9:0]         X_RST    = 10'(XMAX / 2);
  localparam logic [9:0]         Y_RST    = 10'(YMAX / 2);
  localparam logic [SCORE_W-1:0] THRESH_V = SCORE_W'(THRESH);

  state_t               state, state_nxt;
  logic [SCORE_W-1:0]   best, best_nxt;
  logic [9:0]           bx, by, bx_nxt, by_nxt;
  logic                 found, found_nxt;
  logic                 clear, eval, report_go;

  function automatic logic [9:0] clamp(input logic [9:0] v,
                                       input logic [9:0] lo,
                                       input logic [9:0] hi);
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction

  always_comb begin
    state_nxt = state;
    best_nxt  = best;
    bx_nxt    = bx;
    by_nxt    = by;
    found_nxt = found;
    clear     = 1'b0;
    eval      = 1'b0;
    report_go = 1'b0;

    case (state)
      IDLE: begin
        if (tracking_mode && frame_start) begin
          state_nxt = SCAN;
          clear     = 1'b1;
          eval      = 1'b1;
        end
      end
      SCAN: begin
        if (!tracking_mode) begin
          state_nxt = IDLE;
          clear     = 1'b1;
        end else begin
          eval = 1'b1;
          if (frame_start) begin
            clear = 1'b1;
          end else if (frame_end) begin
            state_nxt = REPORT;
            report_go = 1'b1;
          end
        end
      end
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (clear) begin
      best_nxt  = '0;
      found_nxt = 1'b0;
    end

    // Evaluated after the clear so a sample in the frame_start cycle is
    // compared against zero; strict > keeps the earliest of equal scores.
    if (eval && score_valid && (score > best_nxt)) begin
      best_nxt = score;
      bx_nxt   = x;
      by_nxt   = y;
      if (score > THRESH_V) found_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      best      <= '0;
      found     <= 1'b0;
      bx        <= '0;
      by        <= '0;
      max_x     <= X_RST;
      max_y     <= Y_RST;
      max_score <= '0;
      max_ready <= 1'b0;
      lost      <= 1'b0;
    end else begin
      state     <= state_nxt;
      best      <= best_nxt;
      found     <= found_nxt;
      bx        <= bx_nxt;
      by        <= by_nxt;
      max_ready <= 1'b0;
      lost      <= 1'b0;
      // Outputs load on the edge entering REPORT, so the pulse is visible
      // in the REPORT cycle, one cycle after frame_end.
      if (report_go) begin
        if (found_nxt) begin
          max_x     <= clamp(bx_nxt, X_LO, X_HI);
          max_y     <= clamp(by_nxt, Y_LO, Y_HI);
          max_score <= best_nxt;
          max_ready <= 1'b1;
        end else begin
          lost <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_peak_tracker.sv
// tb_peak_tracker
//   Randomized and directed stimulus for peak_tracker. A frame-level model
//   (list of accepted samples, argmax on frame_end) pushes expected reports
//   into a queue; a monitor on the falling edge pops and compares them.

module tb_peak_tracker;

  localparam int SW     = 16;
  localparam int THRESH = 0;
  localparam int HALF   = 16;
  localparam int XMAX   = 640;
  localparam int YMAX   = 480;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tracking_mode = 1'b0;
  logic          frame_start = 1'b0;
  logic          frame_end = 1'b0;
  logic          score_valid = 1'b0;
  logic [9:0]    x = '0;
  logic [9:0]    y = '0;
  logic [SW-1:0] score = '0;
  logic [9:0]    max_x, max_y;
  logic [SW-1:0] max_score;
  logic          max_ready, lost;

  peak_tracker #(.SCORE_W(SW), .THRESH(THRESH), .HALF(HALF),
                 .XMAX(XMAX), .YMAX(YMAX)) dut (
    .clk(clk), .rst(rst), .tracking_mode(tracking_mode),
    .frame_start(frame_start), .frame_end(frame_end),
    .score_valid(score_valid), .x(x), .y(y), .score(score),
    .max_x(max_x), .max_y(max_y), .max_score(max_score),
    .max_ready(max_ready), .lost(lost)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int cyc;
    bit ready;
    int mx;
    int my;
    int ms;
  } exp_t;

  exp_t q[$];
  int   fr_s[$];
  int   fr_x[$];
  int   fr_y[$];
  bit   active = 1'b0;
  int   model_x = XMAX / 2, model_y = YMAX / 2, model_s = 0;
  int   hold_x = XMAX / 2, hold_y = YMAX / 2, hold_s = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int clampv(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // Frame closed at the cycle the frame_end is driven; pulse expected next cycle.
  task automatic close_frame(input int c);
    exp_t e;
    int   m = 0;
    int   idx = -1;
    foreach (fr_s[i]) if (fr_s[i] > m) begin m = fr_s[i]; idx = i; end
    e.cyc = c + 1;
    if (idx >= 0 && m > THRESH) begin
      e.ready = 1'b1;
      model_x = clampv(fr_x[idx], HALF, XMAX - 1 - HALF);
      model_y = clampv(fr_y[idx], HALF, YMAX - 1 - HALF);
      model_s = m;
    end else begin
      e.ready = 1'b0;
    end
    e.mx = model_x;
    e.my = model_y;
    e.ms = model_s;
    q.push_back(e);
  endtask

  task automatic step(input bit tm, input bit fs, input bit fe, input bit v,
                      input int sc, input int xx, input int yy);
    tracking_mode = tm;
    frame_start   = fs;
    frame_end     = fe;
    score_valid   = v;
    score         = SW'(sc);
    x             = 10'(xx);
    y             = 10'(yy);
    if (!tm) begin
      active = 1'b0;
    end else if (fs) begin
      active = 1'b1;
      fr_s.delete(); fr_x.delete(); fr_y.delete();
      if (v) begin fr_s.push_back(sc); fr_x.push_back(xx); fr_y.push_back(yy); end
    end else if (active) begin
      if (v) begin fr_s.push_back(sc); fr_x.push_back(xx); fr_y.push_back(yy); end
      if (fe) begin
        close_frame(cyc);
        active = 1'b0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tracking_mode = 1'b0; frame_start = 1'b0; frame_end = 1'b0; score_valid = 1'b0;
    active  = 1'b0;
    model_x = XMAX / 2; model_y = YMAX / 2; model_s = 0;
    hold_x  = XMAX / 2; hold_y  = YMAX / 2; hold_s  = 0;
    q.delete();
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  task automatic rnd_sample(input bit zero, output bit v, output int sc,
                            output int xx, output int yy);
    v  = ($urandom_range(0, 3) != 0);
    sc = zero ? 0 : int'($urandom_range(0, 15));
    xx = int'($urandom_range(0, 1023));
    yy = int'($urandom_range(0, 1023));
  endtask

  task automatic rand_frame();
    int n;
    bit zero, v;
    int sc, xx, yy, r;
    n    = int'($urandom_range(1, 30));
    zero = ($urandom_range(0, 4) == 0);
    rnd_sample(zero, v, sc, xx, yy);
    step(1, 1, 0, v, sc, xx, yy);
    for (int i = 1; i < n; i++) begin
      rnd_sample(zero, v, sc, xx, yy);
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        step(0, 0, 0, v, sc, xx, yy);
        return;
      end else if (r < 4) begin
        step(1, 1, 0, v, sc, xx, yy);
      end else if (r == 4) begin
        do_reset();
        return;
      end else begin
        step(1, 0, 0, v, sc, xx, yy);
      end
    end
    rnd_sample(zero, v, sc, xx, yy);
    step(1, 0, 1, v, sc, xx, yy);
    for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
      rnd_sample(zero, v, sc, xx, yy);
      step(1'($urandom_range(0, 1)), 0, 0, v, sc, xx, yy);
    end
  endtask

  // Monitor: pulses are popped against the scoreboard; between pulses the
  // registered outputs must hold.
  exp_t e;
  always @(negedge clk) begin
    if (!rst) begin
      if (max_ready || lost) begin
        chk("pulse_exclusive", 32'(max_ready & lost), 0);
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pulse: got ready=%0d lost=%0d expected none (cycle %0d)",
                   max_ready, lost, cyc);
        end else begin
          e = q.pop_front();
          chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
          chk("pulse_ready", 32'(max_ready), 32'(e.ready));
          chk("pulse_max_x", 32'(max_x), 32'(e.mx));
          chk("pulse_max_y", 32'(max_y), 32'(e.my));
          chk("pulse_max_score", 32'(max_score), 32'(e.ms));
          hold_x = e.mx; hold_y = e.my; hold_s = e.ms;
        end
      end else begin
        chk("hold_max_x", 32'(max_x), 32'(hold_x));
        chk("hold_max_y", 32'(max_y), 32'(hold_y));
        chk("hold_max_score", 32'(max_score), 32'(hold_s));
        if (q.size() != 0 && q[0].cyc <= cyc) begin
          e = q.pop_front();
          checks++; errors++;
          $display("FAIL missing_pulse: got none expected ready=%0d at cycle %0d", e.ready, e.cyc);
        end
      end
    end
  end

  initial begin
    @(posedge clk); #1;
    do_reset();
    chk("rst_max_x", 32'(max_x), 320);
    chk("rst_max_y", 32'(max_y), 240);
    chk("rst_max_score", 32'(max_score), 0);
    chk("rst_max_ready", 32'(max_ready), 0);
    chk("rst_lost", 32'(lost), 0);

    // All-zero frame: lost, coordinates unchanged.
    step(1, 1, 0, 1, 0, 10, 10);
    step(1, 0, 0, 1, 0, 20, 20);
    step(1, 0, 1, 1, 0, 30, 30);
    chk("zero_lost", 32'(lost), 1);
    chk("zero_ready", 32'(max_ready), 0);
    idle(2);
    chk("zero_max_x", 32'(max_x), 320);
    chk("zero_max_y", 32'(max_y), 240);

    // Tie keeps earliest.
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 5, 100, 50);
    step(1, 0, 0, 1, 9, 200, 60);
    step(1, 0, 0, 1, 9, 210, 70);
    step(1, 0, 1, 0, 0, 0, 0);
    chk("tie_ready", 32'(max_ready), 1);
    idle(2);
    chk("tie_max_x", 32'(max_x), 200);
    chk("tie_max_y", 32'(max_y), 60);
    chk("tie_max_score", 32'(max_score), 9);

    // Clamp at low x / high y.
    step(1, 1, 0, 1, 50, 3, 470);
    step(1, 0, 1, 0, 0, 0, 0);
    idle(2);
    chk("clamp_max_x", 32'(max_x), 16);
    chk("clamp_max_y", 32'(max_y), 463);

    // Sample in the frame_end cycle wins.
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 30, 100, 100);
    step(1, 0, 1, 1, 40, 300, 200);
    idle(2);
    chk("fe_max_x", 32'(max_x), 300);
    chk("fe_max_y", 32'(max_y), 200);
    chk("fe_max_score", 32'(max_score), 40);

    // tracking_mode dropped mid-frame, then a new frame.
    step(1, 1, 0, 1, 100, 1, 1);
    step(0, 0, 0, 1, 100, 2, 2);
    step(1, 0, 1, 1, 100, 3, 3);
    idle(2);
    step(1, 1, 0, 1, 7, 64, 64);
    step(1, 0, 1, 0, 0, 0, 0);
    idle(2);
    chk("mode_max_x", 32'(max_x), 64);
    chk("mode_max_y", 32'(max_y), 64);
    chk("mode_max_score", 32'(max_score), 7);

    // Reset mid-frame, then frame_end.
    step(1, 1, 0, 1, 12, 400, 300);
    do_reset();
    step(1, 0, 1, 1, 13, 401, 301);
    idle(2);
    chk("rstmid_max_x", 32'(max_x), 320);
    chk("rstmid_max_y", 32'(max_y), 240);
    chk("rstmid_max_score", 32'(max_score), 0);

    for (int f = 0; f < 250; f++) rand_frame();
    idle(5);
    chk("queue_empty", 32'(q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
